// File: rtl/aludec_pkg.sv
// Shared encodings for the pipelined ALU decoder: ALU control words, aluop
// classes, R-type funct codes and FSM state constants.
package aludec_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_NOR  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_SLTU = 4'b1011,
        ALU_MUL  = 4'b1100,
        ALU_DIV  = 4'b1101
    } alu_ctrl_t;

    typedef logic [2:0] aluop_t;
    localparam aluop_t ALUOP_ADD     = 3'b000;
    localparam aluop_t ALUOP_SUB     = 3'b001;
    localparam aluop_t ALUOP_RTYPE   = 3'b010;
    localparam aluop_t ALUOP_AND     = 3'b011;
    localparam aluop_t ALUOP_OR      = 3'b100;
    localparam aluop_t ALUOP_SLT     = 3'b101;
    localparam aluop_t ALUOP_XOR     = 3'b110;
    localparam aluop_t ALUOP_ILLEGAL = 3'b111;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_MUL  = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;

    typedef logic [0:0] state_t;
    localparam state_t S_RUN    = 1'b0;
    localparam state_t S_MDWAIT = 1'b1;

endpackage

// File: rtl/aludec_comb.sv
// Combinational aluop/funct decoder. Illegal encodings fall back to ADD with
// all side flags cleared except illegal.
module aludec_comb
    import aludec_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [2:0] aluop,
    output alu_ctrl_t  alucontrol,
    output logic       use_shamt,
    output logic       multicycle,
    output logic       illegal
);

    // Decode the ALU class first, then the funct field for R-type
    always_comb begin
        alucontrol = ALU_ADD;
        use_shamt  = 1'b0;
        multicycle = 1'b0;
        illegal    = 1'b0;
        unique case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_AND: alucontrol = ALU_AND;
            ALUOP_OR:  alucontrol = ALU_OR;
            ALUOP_SLT: alucontrol = ALU_SLT;
            ALUOP_XOR: alucontrol = ALU_XOR;
            ALUOP_ILLEGAL: illegal = 1'b1;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:  alucontrol = ALU_ADD;
                    FUNCT_SUB:  alucontrol = ALU_SUB;
                    FUNCT_AND:  alucontrol = ALU_AND;
                    FUNCT_OR:   alucontrol = ALU_OR;
                    FUNCT_XOR:  alucontrol = ALU_XOR;
                    FUNCT_NOR:  alucontrol = ALU_NOR;
                    FUNCT_SLT:  alucontrol = ALU_SLT;
                    FUNCT_SLTU: alucontrol = ALU_SLTU;
                    FUNCT_SLL: begin
                        alucontrol = ALU_SLL;
                        use_shamt  = 1'b1;
                    end
                    FUNCT_SRL: begin
                        alucontrol = ALU_SRL;
                        use_shamt  = 1'b1;
                    end
                    FUNCT_SRA: begin
                        alucontrol = ALU_SRA;
                        use_shamt  = 1'b1;
                    end
                    FUNCT_MUL: begin
                        alucontrol = ALU_MUL;
                        multicycle = 1'b1;
                    end
                    FUNCT_DIV: begin
                        alucontrol = ALU_DIV;
                        multicycle = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/aludec_pipe.sv
// Registered, valid/ready ALU decoder between ID and EX. Holds the decoded
// control word, counts accepted illegal ops and blocks issue after mult/div.
module aludec_pipe
    import aludec_pkg::*;
#(
    parameter int unsigned n             = 32,
    parameter int unsigned CTRL_W        = 4,
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        funct,
    input  logic [2:0]        aluop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              use_shamt,
    output logic              multicycle,
    output logic              illegal,
    output logic [ERR_W-1:0]  err_count
);

    localparam int unsigned CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    if (n < 1) begin : g_bad_n
        $error("n must be >= 1");
    end
    if (CTRL_W < 4) begin : g_bad_ctrl_w
        $error("CTRL_W must be >= 4");
    end
    if (MULDIV_CYCLES < 1) begin : g_bad_muldiv
        $error("MULDIV_CYCLES must be >= 1");
    end

    alu_ctrl_t dec_ctrl;
    logic      dec_shamt, dec_mc, dec_ill;

    aludec_comb u_comb (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (dec_ctrl),
        .use_shamt  (dec_shamt),
        .multicycle (dec_mc),
        .illegal    (dec_ill)
    );

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              shamt_q, shamt_d;
    logic              mc_q, mc_d;
    logic              ill_q, ill_d;
    logic [ERR_W-1:0]  err_q, err_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              xfer;

    // Ready never looks at in_valid, so no combinational loop with upstream
    assign in_ready = reset && (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;

    // Output register, error counter and mult/div stall FSM next-state
    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        shamt_d     = shamt_q;
        mc_d        = mc_q;
        ill_d       = ill_q;
        err_d       = err_q;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (xfer) begin
            out_valid_d = 1'b1;
            ctrl_d      = CTRL_W'(dec_ctrl);
            shamt_d     = dec_shamt;
            mc_d        = dec_mc;
            ill_d       = dec_ill;
            if (dec_ill && (err_q != {ERR_W{1'b1}})) begin
                err_d = err_q + ERR_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_RUN: begin
                if (xfer && dec_mc) begin
                    state_d = S_MDWAIT;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_RUN;
                end
            end
        endcase
    end

    // State update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            shamt_q     <= 1'b0;
            mc_q        <= 1'b0;
            ill_q       <= 1'b0;
            err_q       <= '0;
            state_q     <= S_RUN;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            shamt_q     <= shamt_d;
            mc_q        <= mc_d;
            ill_q       <= ill_d;
            err_q       <= err_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alucontrol = ctrl_q;
    assign use_shamt  = shamt_q;
    assign multicycle = mc_q;
    assign illegal    = ill_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_aludec_pipe.sv
// Directed, table-driven bench for aludec_pipe (ERR_W=2, MULDIV_CYCLES=4).
module tb_aludec_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] funct;
    logic [2:0] aluop;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alucontrol;
    logic       use_shamt;
    logic       multicycle;
    logic       illegal;
    logic [1:0] err_count;

    int checks   = 0;
    int failures = 0;

    aludec_pipe #(
        .n             (32),
        .CTRL_W        (4),
        .MULDIV_CYCLES (4),
        .ERR_W         (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .funct      (funct),
        .aluop      (aluop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alucontrol (alucontrol),
        .use_shamt  (use_shamt),
        .multicycle (multicycle),
        .illegal    (illegal),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] aluop;
        logic [5:0] funct;
        logic [3:0] ctrl;
        logic       shamt;
        logic       mc;
        logic       ill;
    } vec_t;

    vec_t vecs[19];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        reset = 1'b1;
    endtask

    initial begin
        int exp_err;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        aluop     = 3'b000;
        funct     = 6'b000000;

        vecs[0]  = '{3'b010, 6'b100000, 4'b0010, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b010, 6'b100010, 4'b0110, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b010, 6'b101010, 4'b0111, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b010, 6'b100100, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b010, 6'b100101, 4'b0001, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b010, 6'b100110, 4'b0011, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b010, 6'b100111, 4'b0100, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b010, 6'b101011, 4'b1011, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b010, 6'b000000, 4'b1000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'b010, 6'b000010, 4'b1001, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'b010, 6'b000011, 4'b1010, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'b000, 6'b111111, 4'b0010, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'b001, 6'b000011, 4'b0110, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'b011, 6'b000000, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'b100, 6'b000000, 4'b0001, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'b101, 6'b000000, 4'b0111, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{3'b110, 6'b000011, 4'b0011, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{3'b111, 6'b100000, 4'b0010, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{3'b010, 6'b111111, 4'b0010, 1'b0, 1'b0, 1'b1};

        // Reset state
        do_reset(2);
        reset = 1'b0;
        #1;
        check("rst in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst alucontrol", alucontrol, 0);
        check("rst use_shamt", use_shamt, 0);
        check("rst multicycle", multicycle, 0);
        check("rst illegal", illegal, 0);
        check("rst err_count", err_count, 0);
        check("rst->run in_ready", in_ready, 1);

        // Back-to-back decode table, one op per cycle
        exp_err = 0;
        for (int i = 0; i < 19; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            aluop     = vecs[i].aluop;
            funct     = vecs[i].funct;
            #1;
            check($sformatf("vec%0d in_ready", i), in_ready, 1);
            step();
            if (vecs[i].ill) exp_err = (exp_err == 3) ? 3 : exp_err + 1;
            check($sformatf("vec%0d out_valid", i), out_valid, 1);
            check($sformatf("vec%0d alucontrol", i), alucontrol, vecs[i].ctrl);
            check($sformatf("vec%0d use_shamt", i), use_shamt, vecs[i].shamt);
            check($sformatf("vec%0d multicycle", i), multicycle, vecs[i].mc);
            check($sformatf("vec%0d illegal", i), illegal, vecs[i].ill);
            check($sformatf("vec%0d err_count", i), err_count, exp_err);
        end
        in_valid = 1'b0;
        step();
        check("drain out_valid", out_valid, 0);
        check("drain holds ctrl", alucontrol, 4'b0010);
        check("illegal err_count", err_count, 2);

        // Backpressure: first result held for 3 cycles, queued op follows
        in_valid = 1'b1;
        aluop    = 3'b010;
        funct    = 6'b100100;
        step();
        check("bp first valid", out_valid, 1);
        check("bp first ctrl", alucontrol, 4'b0000);
        out_ready = 1'b0;
        funct     = 6'b100101;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d in_ready", i), in_ready, 0);
            step();
            check($sformatf("bp%0d out_valid", i), out_valid, 1);
            check($sformatf("bp%0d ctrl held", i), alucontrol, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", in_ready, 1);
        step();
        check("bp next valid", out_valid, 1);
        check("bp next ctrl", alucontrol, 4'b0001);
        in_valid = 1'b0;
        step();
        check("bp drained", out_valid, 0);

        // Multiply: exactly 4 cycles of in_ready=0 after accept
        in_valid = 1'b1;
        funct    = 6'b011000;
        step();
        in_valid = 1'b0;
        check("mul ctrl", alucontrol, 4'b1100);
        check("mul multicycle", multicycle, 1);
        check("mul out_valid", out_valid, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mul stall%0d in_ready", i), in_ready, 0);
            step();
        end
        check("mul resume in_ready", in_ready, 1);

        // Divide with output left unconsumed: stall ends, then handshake rule
        in_valid = 1'b1;
        funct    = 6'b011010;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("div ctrl", alucontrol, 4'b1101);
        for (int i = 0; i < 4; i++) step();
        #1;
        check("div held not ready", in_ready, 0);
        check("div held valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("div consume ready", in_ready, 1);
        step();

        // err_count saturation at 3 after five illegal ops
        do_reset(1);
        check("sat reset err", err_count, 0);
        in_valid = 1'b1;
        aluop    = 3'b111;
        exp_err  = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_err = (exp_err == 3) ? 3 : exp_err + 1;
            check($sformatf("sat%0d err_count", i), err_count, exp_err);
        end
        in_valid = 1'b0;
        step();

        // Reset during the second cycle of the mult/div stall
        in_valid = 1'b1;
        aluop    = 3'b010;
        funct    = 6'b011000;
        step();
        in_valid = 1'b0;
        check("mdrst accepted", multicycle, 1);
        step();
        reset = 1'b0;
        step();
        check("mdrst out_valid", out_valid, 0);
        check("mdrst err_count", err_count, 0);
        check("mdrst multicycle", multicycle, 0);
        check("mdrst alucontrol", alucontrol, 0);
        check("mdrst in_ready low", in_ready, 0);
        reset = 1'b1;
        #1;
        check("mdrst in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aludec_pipe.md
Name: aludec_pipe

Overview:
- Registered, handshaked successor to the single-cycle ALU decoder, used in the pipelined MIPS core between the ID and EX stages.
- Decodes `aluop`/`funct` into a widened ALU control word covering shifts, XOR/NOR, SLTU and multiply/divide.
- Flags illegal encodings and counts them.
- Stalls issue for a parametrised number of cycles after a multiply or divide.

Parameters:
- n, 32, datapath width carried for consistency with sibling blocks; no ports depend on it.
- CTRL_W, 4, alucontrol width; must be ≥ 4.
- MULDIV_CYCLES, 4, cycles issue is blocked after a mult/div is accepted; must be ≥ 1.
- ERR_W, 8, width of the saturating illegal-op counter.

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-low reset; sampled on the clk rising edge.
- in_valid, input, 1, `funct`/`aluop` are valid.
- in_ready, output, 1, block accepts input this cycle.
- funct, input, 6, R-type function field.
- aluop, input, 3, main-decoder ALU class.
- out_valid, output, 1, registered decode result valid.
- out_ready, input, 1, EX stage consumes the result.
- alucontrol, output, CTRL_W, decoded ALU operation.
- use_shamt, output, 1, shift amount comes from the instruction shamt field.
- multicycle, output, 1, operation is mult/div.
- illegal, output, 1, unsupported `aluop`/`funct` combination.
- err_count, output, ERR_W, saturating count of accepted illegal ops.

Behaviour:
- **Reset** (reset=0 at clk edge): out_valid=0, alucontrol=0, use_shamt=0, multicycle=0, illegal=0, err_count=0, state=S_RUN, cnt=0. in_ready=0 while reset=0.
- **aluop decode**:
  - 000 → ADD
  - 001 → SUB
  - 010 → use funct
  - 011 → AND
  - 100 → OR
  - 101 → SLT
  - 110 → XOR
  - 111 → illegal
- **funct decode** (aluop=010):
  - 100000 → ADD
  - 100010 → SUB
  - 100100 → AND
  - 100101 → OR
  - 100110 → XOR
  - 100111 → NOR
  - 101010 → SLT
  - 101011 → SLTU
  - 000000 → SLL, use_shamt=1
  - 000010 → SRL, use_shamt=1
  - 000011 → SRA, use_shamt=1
  - 011000 → MUL, multicycle=1
  - 011010 → DIV, multicycle=1
  - any other value → illegal
- **Illegal result**: alucontrol=ADD, use_shamt=0, multicycle=0, illegal=1.
- **Handshake**:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = reset && state==S_RUN && (!out_valid || out_ready).
  - Latency is 1 cycle: on transfer, the output registers load the decoded values and out_valid=1 on the next cycle.
  - If out_valid && out_ready && no new transfer, out_valid→0 and the other outputs hold their values.
  - While out_valid && !out_ready, outputs are held stable.
  - A new transfer in the same cycle as a consume produces back-to-back results: 1 op/cycle throughput.
- **err_count**: increments on each transfer decoding illegal and saturates at 2^ERR_W−1. It does not wrap.
- **FSM states**: S_RUN, S_MDWAIT.
  - S_RUN → S_MDWAIT on a transfer with multicycle=1; cnt loads MULDIV_CYCLES−1.
  - In S_MDWAIT, in_ready=0.
  - If cnt≠0, cnt decrements.
  - If cnt==0, the FSM returns to S_RUN on the next edge.
  - Net effect: exactly MULDIV_CYCLES cycles of in_ready=0 following the accept cycle, independent of out_ready.
  - If the output is still unconsumed on return to S_RUN, the normal handshake rule applies.
- **Reset mid-operation**: reset=0 in S_MDWAIT or with out_valid=1 discards the pending op and restores all reset values on that edge; err_count also clears.
- in_valid and in_ready do not depend on each other combinationally (in_ready is not a function of in_valid).

Decomposition:
- **Package aludec_pkg**:
  - alu_ctrl_t enum with encodings AND=0000, OR=0001, ADD=0010, XOR=0011, NOR=0100, SUB=0110, SLT=0111, SLL=1000, SRL=1001, SRA=1010, SLTU=1011, MUL=1100, DIV=1101.
  - aluop_t constants.
  - funct localparams.
  - state_t {S_RUN, S_MDWAIT}.
- **Sub-module aludec_comb**: purely combinational, taking (funct, aluop) to (alucontrol, use_shamt, multicycle, illegal). It is instantiated once; the top holds the FSM, counter and output registers.

Test Plan:
- **Basic R-type ops**: reset low 2 cycles, then high; aluop=010 with funct=100000, then 100010, then 101010, in_valid=1, out_ready=1 → alucontrol 0010, 0110, 0111 on consecutive cycles starting 1 cycle after the first accept; illegal=0.
- **Shift**: aluop=010, funct=000011 → alucontrol=1010, use_shamt=1.
- **Immediate class**: aluop=110 → alucontrol=0011, use_shamt=0.
- **Backpressure**: out_ready=0 for 3 cycles after the first result → out_valid and alucontrol held; in_ready=0 during those cycles. On out_ready=1, the next queued op follows on the next cycle.
- **Multicycle stall**: MULDIV_CYCLES=4, aluop=010, funct=011000 → alucontrol=1100, multicycle=1; in_ready=0 for exactly 4 cycles after the accept, then 1.
- **Illegal encodings**: aluop=111, then aluop=010 with funct=111111 → illegal=1, alucontrol=0010, err_count=2.
- **err_count saturation**: ERR_W=2 with 5 illegal ops → err_count saturates at 3.
- **Reset mid-stall**: reset=0 in the 2nd cycle of S_MDWAIT → next cycle out_valid=0, err_count=0, and in_ready=1 once reset=1.
